serial_pattern_generator: RTL and testbench
===========================================

# serial_pattern_generator

Serial bit-pattern transmitter that produces the one-bit-per-clock input stream consumed by the sequence-detector family. On a start request it latches a pattern, a length, a repeat count and an inter-repeat gap, then shifts the pattern out MSB-first with a valid qualifier. It serves as the stimulus source for detector benches and as the transmit end of the serial link.

## Interface
- WIDTH, default 8: maximum pattern length in bits; legal range 2..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; bit len-1 goes first, bit 0 goes last.
- len  input  4  number of bits per transmission; 0 or values greater than WIDTH are treated as WIDTH.
- reps  input  4  number of transmissions; 0 is treated as 1.
- gap  input  4  idle cycles inserted between consecutive transmissions; 0 means back-to-back.
- out  output  1  serial data bit.
- valid  output  1  high while out carries a pattern bit.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the final bit.
- state  output  3  current FSM state, for debug.

## Operation
- FSM states: IDLE=0, SHIFT=1, GAP=2, DONE=3. Encodings 4..7 are unused; if reached, the next edge returns to IDLE.
- IDLE, start=1:
  - Latch pattern, effective len L, effective reps R and gap G into internal registers.
  - Load the shift register so the MSB is pattern[L-1].
  - bit_cnt=L-1, rep_cnt=R-1. Go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT:
  - out = current MSB of the shift register; valid=1.
  - Each edge shifts left by one and decrements bit_cnt.
  - When bit_cnt=0 at the edge:
    - rep_cnt=0: go to DONE.
    - Otherwise G>0: go to GAP with gap_cnt=G-1.
    - Otherwise (G=0): reload the shift register, bit_cnt=L-1, decrement rep_cnt, stay in SHIFT.
- GAP:
  - out=0, valid=0.
  - gap_cnt decrements each edge.
  - At gap_cnt=0: reload the shift register, bit_cnt=L-1, decrement rep_cnt, go to SHIFT.
- DONE: done=1, out=0, valid=0. The next edge goes to IDLE unconditionally.
- start is ignored in SHIFT, GAP and DONE. Input pins may change freely after latching without affecting the transfer in progress.
- No gap is inserted after the last transmission.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Reset: at the edge where rst=1, state=IDLE, out=0, valid=0, busy=0, done=0, and all counters clear. This applies in any state, including mid-transfer. rst takes priority over start in the same cycle.

## Timing
- start is sampled high at edge k. The first bit appears on out after edge k with valid=1 and busy=1.
- Bit i of a transmission is held from edge k+i to edge k+i+1.
- Total SHIFT+GAP cycles = R·L + (R-1)·G.
- DONE is entered at edge k + R·L + (R-1)·G. done is high for exactly that one cycle. IDLE follows at the next edge.
- A new start can be accepted at the first edge where state=IDLE, giving a 2-cycle minimum turnaround after the last bit.
- The 1-cycle latency from start to the first bit is fixed and is independent of L, R and G.

## Test plan
- Single transmission:
  - Stimulus: rst held 3 cycles, then start with pattern=8'h0B, len=4, reps=1, gap=0.
  - Required: out=1,0,1,1 on 4 consecutive cycles with valid=1, done pulses in the 5th cycle, state sequence 1,1,1,1,3,0.
- Back-to-back repeats:
  - Stimulus: pattern=8'h0B, len=4, reps=2, gap=0.
  - Required: out=1,0,1,1,1,0,1,1 with valid continuously high for 8 cycles, done in cycle 9.
- Gap insertion:
  - Stimulus: pattern=8'h06 (110), len=3, reps=3, gap=2.
  - Required: out/valid = 1,1,0 then 0/0 ×2, then 1,1,0, then 0/0 ×2, then 1,1,0, then done. 13 busy cycles before DONE, no trailing gap.
- Length clamping and rep default:
  - Stimulus: pattern=8'hA5, len=0, reps=0. Then repeat with len=12.
  - Required: both runs emit 1,0,1,0,0,1,0,1 exactly once, then done.
- Start while busy and input change:
  - Stimulus: start=1 held continuously, with pattern changed to 8'hFF in the 2nd SHIFT cycle of an 8'h0B/len=4 transfer.
  - Required: the original 1011 is sent unchanged, and no second transfer begins until state returns to IDLE.
  - Required: with start still high, a new transfer of 1111 begins the edge after IDLE is reached.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle during the 3rd bit of a reps=2 transfer.
  - Required: at the next edge out=0, valid=0, busy=0, done=0, state=0. No done pulse occurs and the generator stays in IDLE until a new start.

Source files
------------

// File: rtl/serial_pattern_generator.sv
// Serial bit-pattern transmitter.
// A start request latches the pattern, length, repeat count and inter-repeat
// gap. The pattern is then shifted out MSB-first, one bit per clock, with a
// valid qualifier. Optional idle gaps separate the repeats, and a one-cycle
// done pulse follows the final bit.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; all outputs low
//   SHIFT | out carries pattern bits, valid high
//   GAP   | idle cycles between consecutive transmissions
//   DONE  | one-cycle done pulse, then back to IDLE
//
// out, valid, busy and done are all flops. They are loaded with the values
// that belong to the next state, so no input reaches an output
// combinationally.
module serial_pattern_generator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [3:0]       len,
  input  logic [3:0]       reps,
  input  logic [3:0]       gap,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam logic [3:0] W4 = 4'(WIDTH);

  state_t           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] pat_q;
  logic [3:0]       len_q;
  logic [3:0]       gap_q;
  logic [3:0]       bit_cnt_q;
  logic [3:0]       rep_cnt_q;
  logic [3:0]       gap_cnt_q;
  logic             out_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;

  logic [3:0]       len_eff;
  logic [3:0]       reps_eff;
  logic [WIDTH-1:0] load_in;
  logic [WIDTH-1:0] load_pat;

  // Shift the pattern up so that bit l-1 lands in the MSB of the shift register.
  function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] p,
                                             input logic [3:0]       l);
    return p << (W4 - l);
  endfunction

  // Out-of-range length falls back to WIDTH, and zero repeats means one.
  always_comb begin
    len_eff  = ((len == 4'd0) || (len > W4)) ? W4 : len;
    reps_eff = (reps == 4'd0) ? 4'd1 : reps;
    load_in  = align(pattern, len_eff);
    load_pat = align(pat_q, len_q);
  end

  // Sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      gap_q     <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            pat_q     <= pattern;
            len_q     <= len_eff;
            gap_q     <= gap;
            shreg_q   <= load_in;
            bit_cnt_q <= len_eff - 4'd1;
            rep_cnt_q <= reps_eff - 4'd1;
            state_q   <= ST_SHIFT;
            out_q     <= load_in[WIDTH-1];
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
          end else begin
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt_q == 4'd0) begin
            if (rep_cnt_q == 4'd0) begin
              state_q <= ST_DONE;
              out_q   <= 1'b0;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else if (gap_q != 4'd0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= gap_q - 4'd1;
              out_q     <= 1'b0;
              valid_q   <= 1'b0;
            end else begin
              // Back-to-back repeat: reload without leaving SHIFT.
              shreg_q   <= load_pat;
              bit_cnt_q <= len_q - 4'd1;
              rep_cnt_q <= rep_cnt_q - 4'd1;
              out_q     <= load_pat[WIDTH-1];
              valid_q   <= 1'b1;
            end
          end else begin
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q - 4'd1;
            out_q     <= shreg_q[WIDTH-2];
            valid_q   <= 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q   <= ST_SHIFT;
            shreg_q   <= load_pat;
            bit_cnt_q <= len_q - 4'd1;
            rep_cnt_q <= rep_cnt_q - 4'd1;
            out_q     <= load_pat[WIDTH-1];
            valid_q   <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end

        default: begin
          // Unused encodings recover to IDLE.
          state_q <= ST_IDLE;
          out_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign state = state_q;

endmodule

// File: tb/tb_serial_pattern_generator.sv
// Bench for serial_pattern_generator. Expected per-cycle outputs come from a
// reference model that works out the output stream from the pattern, the
// effective length, the repeat count and the gap using plain arithmetic.
module tb_serial_pattern_generator;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic [3:0] gap;
  logic       out_w;
  logic       valid_w;
  logic       busy_w;
  logic       done_w;
  logic [2:0] state_w;

  int n_pass;
  int n_checks;

  serial_pattern_generator #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pattern(pattern),
    .len    (len),
    .reps   (reps),
    .gap    (gap),
    .out    (out_w),
    .valid  (valid_w),
    .busy   (busy_w),
    .done   (done_w),
    .state  (state_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {state, busy, valid, done, out}.
  function automatic logic [6:0] observed();
    return {state_w, busy_w, valid_w, done_w, out_w};
  endfunction

  // Reference model: expected outputs j cycles after the start edge.
  function automatic logic [6:0] model(input int j, input logic [7:0] pat,
                                       input int l, input int r, input int g);
    int n;
    int t;
    n = r * l + (r - 1) * g;
    if (j < n) begin
      t = j % (l + g);
      if (t < l) return {3'd1, 1'b1, 1'b1, 1'b0, pat[l-1-t]};
      return {3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    end
    if (j == n) return {3'd3, 1'b1, 1'b0, 1'b1, 1'b0};
    return 7'd0;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed {st,busy,vld,done,out}=%b required %b", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches one transfer and checks every cycle through DONE and back to
  // IDLE. With hold set, start stays high and only the pattern changes (in
  // the 2nd SHIFT cycle); otherwise all inputs are scrambled after latching.
  task automatic run_xfer(input string tag, input logic [7:0] p, input logic [3:0] ln,
                          input logic [3:0] rp, input logic [3:0] gp, input bit hold,
                          input logic [7:0] post_pat);
    int l;
    int r;
    int g;
    int n;
    l = (ln == 0 || ln > 8) ? 8 : int'(ln);
    r = (rp == 0) ? 1 : int'(rp);
    g = int'(gp);
    n = r * l + (r - 1) * g;
    pattern = p;
    len     = ln;
    reps    = rp;
    gap     = gp;
    start   = 1'b1;
    step();
    for (int j = 0; j <= n + 1; j++) begin
      check($sformatf("%s[%0d]", tag, j), observed(), model(j, p, l, r, g));
      if (!hold && j == 0) begin
        start   = 1'b0;
        pattern = 8'($urandom);
        len     = 4'($urandom);
        reps    = 4'($urandom);
        gap     = 4'($urandom);
      end
      if (j == 1) pattern = post_pat;
      if (j <= n) step();
    end
  endtask

  initial begin
    n_pass   = 0;
    n_checks = 0;
    start    = 1'b0;
    pattern  = 8'h00;
    len      = 4'd0;
    reps     = 4'd0;
    gap      = 4'd0;
    rst      = 1'b1;
    #1;
    repeat (3) step();
    check("reset", observed(), 7'd0);
    rst = 1'b0;
    step();
    check("idle_after_reset", observed(), 7'd0);

    run_xfer("single",      8'h0B, 4'd4,  4'd1, 4'd0, 1'b0, 8'($urandom));
    run_xfer("b2b",         8'h0B, 4'd4,  4'd2, 4'd0, 1'b0, 8'($urandom));
    run_xfer("gap",         8'h06, 4'd3,  4'd3, 4'd2, 1'b0, 8'($urandom));
    run_xfer("len0_reps0",  8'hA5, 4'd0,  4'd0, 4'd0, 1'b0, 8'($urandom));
    run_xfer("len12",       8'hA5, 4'd12, 4'd0, 4'd0, 1'b0, 8'($urandom));
    run_xfer("len2_gap1",   8'h02, 4'd2,  4'd4, 4'd1, 1'b0, 8'($urandom));

    // Start held high: the running transfer is unaffected, and the retrigger
    // latches the new pattern on the edge after IDLE is reached.
    run_xfer("held_first",  8'h0B, 4'd4,  4'd1, 4'd0, 1'b1, 8'hFF);
    run_xfer("held_second", 8'hFF, 4'd4,  4'd1, 4'd0, 1'b0, 8'($urandom));

    // Reset during the 3rd bit of a two-repeat transfer.
    pattern = 8'h0B;
    len     = 4'd4;
    reps    = 4'd2;
    gap     = 4'd0;
    start   = 1'b1;
    step();
    check("rstmid_b0", observed(), model(0, 8'h0B, 4, 2, 0));
    start = 1'b0;
    step();
    check("rstmid_b1", observed(), model(1, 8'h0B, 4, 2, 0));
    step();
    check("rstmid_b2", observed(), model(2, 8'h0B, 4, 2, 0));
    rst = 1'b1;
    step();
    check("rstmid_cleared", observed(), 7'd0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("rstmid_stay_idle[%0d]", i), observed(), 7'd0);
    end

    // Reset wins over start in the same cycle.
    rst   = 1'b1;
    start = 1'b1;
    step();
    check("rst_over_start", observed(), 7'd0);
    rst   = 1'b0;
    start = 1'b0;
    step();
    check("rst_over_start_idle", observed(), 7'd0);

    // Randomized transfers against the reference model.
    for (int k = 0; k < 25; k++) begin
      run_xfer($sformatf("rand%0d", k), 8'($urandom), 4'($urandom), 4'($urandom),
               4'($urandom_range(0, 5)), 1'b0, 8'($urandom));
      repeat ($urandom_range(0, 2)) begin
        step();
        check($sformatf("rand%0d_idle", k), observed(), 7'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
